// File: rtl/router_pkg.sv
// Shared mesh-router definitions: flit types, port indices, field offsets and XY routing.
package router_pkg;

  localparam int unsigned NUM_PORT    = 5;
  localparam int unsigned PORT_LOCAL  = 0;
  localparam int unsigned PORT_N      = 1;
  localparam int unsigned PORT_E      = 2;
  localparam int unsigned PORT_S      = 3;
  localparam int unsigned PORT_W      = 4;

  localparam int unsigned TYPE_W      = 2;
  localparam int unsigned DEST_X_LSB  = 0;
  localparam int unsigned COORD_W_MAX = 16;

  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_HEAD   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  // Dimension-order route: resolve X first, then Y, else eject locally.
  function automatic logic [NUM_PORT-1:0] xy_route(
    input logic [COORD_W_MAX-1:0] dst_x,
    input logic [COORD_W_MAX-1:0] my_x,
    input logic [COORD_W_MAX-1:0] dst_y,
    input logic [COORD_W_MAX-1:0] my_y
  );
    logic [NUM_PORT-1:0] r;
    if (dst_x > my_x)      r = NUM_PORT'(1) << PORT_E;
    else if (dst_x < my_x) r = NUM_PORT'(1) << PORT_W;
    else if (dst_y > my_y) r = NUM_PORT'(1) << PORT_S;
    else if (dst_y < my_y) r = NUM_PORT'(1) << PORT_N;
    else                   r = NUM_PORT'(1) << PORT_LOCAL;
    return r;
  endfunction

endpackage

// File: rtl/router_input_unit_if.sv
// Upstream link + switch-allocator handshake bundle for one router input port.
interface router_input_unit_if #(
  parameter int unsigned DATA_W   = 35,
  parameter int unsigned NUM_VC   = 2,
  parameter int unsigned XW       = 2,
  parameter int unsigned YW       = 2,
  parameter int unsigned NUM_PORT = 5
);
  localparam int unsigned VCW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

  logic [DATA_W-1:0]          IDATA;
  logic                       IVALID;
  logic [VCW-1:0]             IVCH;
  logic [NUM_VC-1:0]          OACK;
  logic [NUM_VC-1:0]          ORDY;
  logic [NUM_VC-1:0]          OLCK;
  logic [XW-1:0]              MY_XPOS;
  logic [YW-1:0]              MY_YPOS;
  logic [NUM_VC*DATA_W-1:0]   SW_DATA;
  logic [NUM_VC-1:0]          SW_VALID;
  logic [NUM_VC*NUM_PORT-1:0] SW_PORT;
  logic [NUM_VC-1:0]          SW_GNT;
  logic                       ERR;

  modport master (
    output IDATA, IVALID, IVCH, MY_XPOS, MY_YPOS, SW_GNT,
    input  OACK, ORDY, OLCK, SW_DATA, SW_VALID, SW_PORT, ERR
  );

  modport slave (
    input  IDATA, IVALID, IVCH, MY_XPOS, MY_YPOS, SW_GNT,
    output OACK, ORDY, OLCK, SW_DATA, SW_VALID, SW_PORT, ERR
  );
endinterface

// File: rtl/router_vc_fifo.sv
// Single-VC circular flit buffer with occupancy count and registered ready.
module router_vc_fifo #(
  parameter int unsigned DATA_W = 35,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              empty_o,
  output logic              rdy_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              rdy_q, rdy_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en_i) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(wr_en_i) - CNT_W'(rd_en_i);
    rdy_d   = (count_d < CNT_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdy_q    <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdy_q    <= rdy_d;
    end
  end

  // Storage carries no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign empty_o   = (count_q == '0);
  assign rdy_o     = rdy_q;

endmodule

// File: rtl/router_input_unit.sv
// Mesh NoC router input port: per-VC FIFOs, upstream handshakes, XY route request.
// Optional per-VC enqueue counters when RTR_INPUT_PERF_CNT_EN is defined.
module router_input_unit #(
  parameter int unsigned DATA_W   = 35,
  parameter int unsigned NUM_VC   = 2,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned XW       = 2,
  parameter int unsigned YW       = 2,
  parameter int unsigned NUM_PORT = 5
) (
  input  logic                   clk,
  input  logic                   RST,
`ifdef RTR_INPUT_PERF_CNT_EN
  input  logic                   PERF_CLR,
  output logic [NUM_VC*16-1:0]   PERF_FLITS,
`endif
  router_input_unit_if.slave     bus
);
  import router_pkg::*;

  logic [NUM_VC-1:0]          wr_en_c, rd_en_c, empty_c, rdy_c;
  logic [DATA_W-1:0]          head_c   [NUM_VC];
  logic [NUM_PORT-1:0]        hroute_c [NUM_VC];
  logic [NUM_PORT-1:0]        route_q  [NUM_VC];
  logic [NUM_PORT-1:0]        route_d  [NUM_VC];
  logic [NUM_VC-1:0]          ack_q, ack_d, lck_q, lck_d;
  logic                       err_q, err_d;
  logic [TYPE_W-1:0]          in_type_c;
  logic [NUM_VC*DATA_W-1:0]   sw_data_c;
  logic [NUM_VC*NUM_PORT-1:0] sw_port_c;

  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
    router_vc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_i     (RST),
      .wr_en_i   (wr_en_c[g]),
      .wr_data_i (bus.IDATA),
      .rd_en_i   (rd_en_c[g]),
      .rd_data_o (head_c[g]),
      .empty_o   (empty_c[g]),
      .rdy_o     (rdy_c[g])
    );
  end

  // Enqueue/dequeue decode, lock tracking and error detection.
  always_comb begin
    wr_en_c   = '0;
    rd_en_c   = '0;
    lck_d     = lck_q;
    err_d     = err_q;
    in_type_c = bus.IDATA[DATA_W-1 -: TYPE_W];
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      wr_en_c[v] = bus.IVALID && (32'(bus.IVCH) == v) && rdy_c[v];
      rd_en_c[v] = bus.SW_GNT[v] && !empty_c[v];
      if (bus.SW_GNT[v] && empty_c[v]) err_d = 1'b1;
      if (wr_en_c[v]) begin
        if ((in_type_c == FLIT_HEAD) || (in_type_c == FLIT_SINGLE)) begin
          if (lck_q[v]) err_d = 1'b1;
        end else if (!lck_q[v]) begin
          err_d = 1'b1;
        end
        if (in_type_c == FLIT_HEAD) lck_d[v] = 1'b1;
        if (in_type_c == FLIT_TAIL) lck_d[v] = 1'b0;
      end
    end
    if (bus.IVALID && (wr_en_c == '0)) err_d = 1'b1;
    ack_d = wr_en_c;
  end

  // Head flits route live; body/tail reuse the route latched when their head left.
  always_comb begin
    sw_data_c = '0;
    sw_port_c = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      hroute_c[v] = NUM_PORT'(xy_route(
        COORD_W_MAX'(head_c[v][DEST_X_LSB +: XW]), COORD_W_MAX'(bus.MY_XPOS),
        COORD_W_MAX'(head_c[v][DEST_X_LSB+XW +: YW]), COORD_W_MAX'(bus.MY_YPOS)));
      route_d[v] = route_q[v];
      sw_data_c[v*DATA_W +: DATA_W] = head_c[v];
      if ((head_c[v][DATA_W-1 -: TYPE_W] == FLIT_HEAD) ||
          (head_c[v][DATA_W-1 -: TYPE_W] == FLIT_SINGLE)) begin
        sw_port_c[v*NUM_PORT +: NUM_PORT] = hroute_c[v];
      end else begin
        sw_port_c[v*NUM_PORT +: NUM_PORT] = route_q[v];
      end
      if (rd_en_c[v] && (head_c[v][DATA_W-1 -: TYPE_W] == FLIT_HEAD)) route_d[v] = hroute_c[v];
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      ack_q <= '0;
      lck_q <= '0;
      err_q <= 1'b0;
      for (int unsigned v = 0; v < NUM_VC; v++) route_q[v] <= '0;
    end else begin
      ack_q <= ack_d;
      lck_q <= lck_d;
      err_q <= err_d;
      for (int unsigned v = 0; v < NUM_VC; v++) route_q[v] <= route_d[v];
    end
  end

  assign bus.OACK     = ack_q;
  assign bus.ORDY     = rdy_c;
  assign bus.OLCK     = lck_q;
  assign bus.ERR      = err_q;
  assign bus.SW_VALID = ~empty_c;
  assign bus.SW_DATA  = sw_data_c;
  assign bus.SW_PORT  = sw_port_c;

`ifdef RTR_INPUT_PERF_CNT_EN
  logic [15:0] perf_q [NUM_VC];
  logic [15:0] perf_d [NUM_VC];

  // Clear wins over a same-cycle enqueue; counters saturate at all-ones.
  always_comb begin
    PERF_FLITS = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      perf_d[v] = perf_q[v];
      if (PERF_CLR)                                perf_d[v] = '0;
      else if (wr_en_c[v] && (perf_q[v] != 16'hFFFF)) perf_d[v] = perf_q[v] + 16'd1;
      PERF_FLITS[v*16 +: 16] = perf_q[v];
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      for (int unsigned v = 0; v < NUM_VC; v++) perf_q[v] <= '0;
    end else begin
      for (int unsigned v = 0; v < NUM_VC; v++) perf_q[v] <= perf_d[v];
    end
  end
`endif

endmodule

// File: tb/tb_router_input_unit.sv
// Directed self-checking bench for router_input_unit (router at X=1, Y=1).
module tb_router_input_unit;
  import router_pkg::*;

  localparam int unsigned DATA_W = 35;
  localparam int unsigned NUM_VC = 2;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned XW     = 2;
  localparam int unsigned YW     = 2;
  localparam int unsigned NP     = 5;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  router_input_unit_if #(.DATA_W(DATA_W), .NUM_VC(NUM_VC), .XW(XW), .YW(YW), .NUM_PORT(NP)) bus ();

`ifdef RTR_INPUT_PERF_CNT_EN
  logic                      perf_clr;
  logic [NUM_VC*16-1:0]      perf_flits;
`endif

  router_input_unit #(
    .DATA_W(DATA_W), .NUM_VC(NUM_VC), .DEPTH(DEPTH), .XW(XW), .YW(YW), .NUM_PORT(NP)
  ) dut (
    .clk        (clk),
    .RST        (rst),
`ifdef RTR_INPUT_PERF_CNT_EN
    .PERF_CLR   (perf_clr),
    .PERF_FLITS (perf_flits),
`endif
    .bus        (bus)
  );

  function automatic logic [DATA_W-1:0] mk(input logic [1:0] t, input logic [XW-1:0] dx,
                                           input logic [YW-1:0] dy, input logic [7:0] tag);
    return {t, 21'd0, tag, dy, dx};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int unsigned vc, input logic [DATA_W-1:0] d);
    bus.IVALID = 1'b1;
    bus.IVCH   = 1'(vc);
    bus.IDATA  = d;
    tick();
    bus.IVALID = 1'b0;
  endtask

  task automatic do_reset();
    bus.IVALID = 1'b0;
    bus.SW_GNT = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.OACK !== 2'b00) begin errors++; $display("FAIL reset_oack got=%b want=00", bus.OACK); end
    checks++; if (bus.ORDY !== 2'b11) begin errors++; $display("FAIL reset_ordy got=%b want=11", bus.ORDY); end
    checks++; if (bus.OLCK !== 2'b00) begin errors++; $display("FAIL reset_olck got=%b want=00", bus.OLCK); end
    checks++; if (bus.SW_VALID !== 2'b00) begin errors++; $display("FAIL reset_swvalid got=%b want=00", bus.SW_VALID); end
    checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", bus.ERR); end
  endtask

  task automatic test_single_east();
    logic [DATA_W-1:0] f;
    do_reset();
    f = mk(FLIT_SINGLE, 2'd3, 2'd1, 8'h11);
    send(0, f);
    checks++; if (bus.OACK !== 2'b01) begin errors++; $display("FAIL east_oack got=%b want=01", bus.OACK); end
    checks++; if (bus.SW_VALID !== 2'b01) begin errors++; $display("FAIL east_swvalid got=%b want=01", bus.SW_VALID); end
    checks++; if (bus.SW_PORT[4:0] !== 5'b00100) begin errors++; $display("FAIL east_port got=%b want=00100", bus.SW_PORT[4:0]); end
    checks++; if (bus.SW_DATA[34:0] !== f) begin errors++; $display("FAIL east_data got=%h want=%h", bus.SW_DATA[34:0], f); end
    tick();
    checks++; if (bus.OACK !== 2'b00) begin errors++; $display("FAIL east_ack_pulse got=%b want=00", bus.OACK); end
    bus.SW_GNT = 2'b01;
    tick();
    bus.SW_GNT = 2'b00;
    checks++; if (bus.SW_VALID !== 2'b00) begin errors++; $display("FAIL east_drain got=%b want=00", bus.SW_VALID); end
    checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL east_err got=%b want=0", bus.ERR); end
  endtask

  task automatic test_packet_north();
    logic [DATA_W-1:0] fl [4];
    do_reset();
    fl[0] = mk(FLIT_HEAD, 2'd1, 2'd0, 8'h20);
    fl[1] = mk(FLIT_BODY, 2'd3, 2'd3, 8'h21);
    fl[2] = mk(FLIT_BODY, 2'd3, 2'd3, 8'h22);
    fl[3] = mk(FLIT_TAIL, 2'd3, 2'd3, 8'h23);
    for (int i = 0; i < 4; i++) begin
      bus.IVALID = 1'b1;
      bus.IVCH   = 1'b1;
      bus.IDATA  = fl[i];
      bus.SW_GNT = {bus.SW_VALID[1], 1'b0};
      tick();
      checks++; if (bus.OACK !== 2'b10) begin errors++; $display("FAIL pkt_oack[%0d] got=%b want=10", i, bus.OACK); end
      checks++; if (bus.OLCK[1] !== (i < 3)) begin errors++; $display("FAIL pkt_olck[%0d] got=%b want=%b", i, bus.OLCK[1], (i < 3)); end
      checks++; if (bus.SW_PORT[9:5] !== 5'b00010) begin errors++; $display("FAIL pkt_port[%0d] got=%b want=00010", i, bus.SW_PORT[9:5]); end
      checks++; if (bus.SW_DATA[69:35] !== fl[i]) begin errors++; $display("FAIL pkt_data[%0d] got=%h want=%h", i, bus.SW_DATA[69:35], fl[i]); end
    end
    bus.IVALID = 1'b0;
    bus.SW_GNT = 2'b10;
    tick();
    bus.SW_GNT = 2'b00;
    checks++; if (bus.SW_VALID !== 2'b00) begin errors++; $display("FAIL pkt_drain got=%b want=00", bus.SW_VALID); end
    checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL pkt_err got=%b want=0", bus.ERR); end
  endtask

  task automatic test_fill_drop();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(0, mk(FLIT_SINGLE, 2'd1, 2'd1, 8'(8'h30 + i)));
      checks++; if (bus.ORDY[0] !== (i < 3)) begin errors++; $display("FAIL fill_ordy[%0d] got=%b want=%b", i, bus.ORDY[0], (i < 3)); end
    end
    checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL fill_err_pre got=%b want=0", bus.ERR); end
    send(0, mk(FLIT_SINGLE, 2'd1, 2'd1, 8'h34));
    checks++; if (bus.OACK !== 2'b00) begin errors++; $display("FAIL drop_oack got=%b want=00", bus.OACK); end
    checks++; if (bus.ERR !== 1'b1) begin errors++; $display("FAIL drop_err got=%b want=1", bus.ERR); end
    checks++; if (bus.SW_DATA[34:0] !== mk(FLIT_SINGLE, 2'd1, 2'd1, 8'h30)) begin errors++; $display("FAIL drop_head got=%h", bus.SW_DATA[34:0]); end
    send(1, mk(FLIT_SINGLE, 2'd0, 2'd0, 8'h40));
    checks++; if (bus.OACK !== 2'b10) begin errors++; $display("FAIL vc1_oack got=%b want=10", bus.OACK); end
    checks++; if (bus.SW_VALID !== 2'b11) begin errors++; $display("FAIL vc1_swvalid got=%b want=11", bus.SW_VALID); end
  endtask

  task automatic test_full_enq_gnt();
    do_reset();
    for (int i = 0; i < 4; i++) send(0, mk(FLIT_SINGLE, 2'd1, 2'd1, 8'(8'h50 + i)));
    bus.IVALID = 1'b1;
    bus.IVCH   = 1'b0;
    bus.IDATA  = mk(FLIT_SINGLE, 2'd1, 2'd1, 8'h5F);
    bus.SW_GNT = 2'b01;
    tick();
    bus.IVALID = 1'b0;
    bus.SW_GNT = 2'b00;
    checks++; if (bus.OACK !== 2'b00) begin errors++; $display("FAIL fullgnt_oack got=%b want=00", bus.OACK); end
    checks++; if (bus.ORDY[0] !== 1'b1) begin errors++; $display("FAIL fullgnt_ordy got=%b want=1", bus.ORDY[0]); end
    checks++; if (bus.ERR !== 1'b1) begin errors++; $display("FAIL fullgnt_err got=%b want=1", bus.ERR); end
    checks++; if (bus.SW_DATA[34:0] !== mk(FLIT_SINGLE, 2'd1, 2'd1, 8'h51)) begin errors++; $display("FAIL fullgnt_head got=%h", bus.SW_DATA[34:0]); end
    send(0, mk(FLIT_SINGLE, 2'd1, 2'd1, 8'h54));
    checks++; if (bus.OACK !== 2'b01) begin errors++; $display("FAIL cnt3_oack got=%b want=01", bus.OACK); end
    checks++; if (bus.ORDY[0] !== 1'b0) begin errors++; $display("FAIL cnt3_ordy got=%b want=0", bus.ORDY[0]); end
  endtask

  task automatic test_local_and_empty_gnt();
    logic [DATA_W-1:0] f;
    do_reset();
    f = mk(FLIT_SINGLE, 2'd1, 2'd1, 8'h60);
    send(0, f);
    checks++; if (bus.SW_PORT[4:0] !== 5'b00001) begin errors++; $display("FAIL local_port got=%b want=00001", bus.SW_PORT[4:0]); end
    bus.SW_GNT = 2'b10;
    tick();
    bus.SW_GNT = 2'b00;
    checks++; if (bus.ERR !== 1'b1) begin errors++; $display("FAIL egnt_err got=%b want=1", bus.ERR); end
    checks++; if (bus.SW_VALID !== 2'b01) begin errors++; $display("FAIL egnt_swvalid got=%b want=01", bus.SW_VALID); end
    checks++; if (bus.ORDY !== 2'b11) begin errors++; $display("FAIL egnt_ordy got=%b want=11", bus.ORDY); end
    checks++; if (bus.SW_DATA[34:0] !== f) begin errors++; $display("FAIL egnt_data got=%h want=%h", bus.SW_DATA[34:0], f); end
  endtask

  task automatic test_proto_err();
    do_reset();
    send(0, mk(FLIT_BODY, 2'd3, 2'd0, 8'h70));
    checks++; if (bus.ERR !== 1'b1) begin errors++; $display("FAIL proto_err got=%b want=1", bus.ERR); end
    checks++; if (bus.OACK !== 2'b01) begin errors++; $display("FAIL proto_oack got=%b want=01", bus.OACK); end
    checks++; if (bus.OLCK !== 2'b00) begin errors++; $display("FAIL proto_olck got=%b want=00", bus.OLCK); end
    checks++; if (bus.SW_PORT[4:0] !== 5'b00000) begin errors++; $display("FAIL proto_port got=%b want=00000", bus.SW_PORT[4:0]); end
  endtask

  task automatic test_reset_midpacket();
    do_reset();
    send(0, mk(FLIT_HEAD, 2'd2, 2'd1, 8'h80));
    send(0, mk(FLIT_BODY, 2'd0, 2'd0, 8'h81));
    send(0, mk(FLIT_BODY, 2'd0, 2'd0, 8'h82));
    checks++; if (bus.OLCK !== 2'b01) begin errors++; $display("FAIL mid_olck_pre got=%b want=01", bus.OLCK); end
    checks++; if (bus.ORDY !== 2'b11) begin errors++; $display("FAIL mid_ordy_pre got=%b want=11", bus.ORDY); end
    bus.SW_GNT = 2'b10;
    tick();
    bus.SW_GNT = 2'b00;
    checks++; if (bus.ERR !== 1'b1) begin errors++; $display("FAIL mid_err_pre got=%b want=1", bus.ERR); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.SW_VALID !== 2'b00) begin errors++; $display("FAIL mid_swvalid got=%b want=00", bus.SW_VALID); end
    checks++; if (bus.OLCK !== 2'b00) begin errors++; $display("FAIL mid_olck got=%b want=00", bus.OLCK); end
    checks++; if (bus.ORDY !== 2'b11) begin errors++; $display("FAIL mid_ordy got=%b want=11", bus.ORDY); end
    checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL mid_err got=%b want=0", bus.ERR); end
  endtask

  initial begin
    rst         = 1'b1;
    bus.IVALID  = 1'b0;
    bus.IVCH    = '0;
    bus.IDATA   = '0;
    bus.SW_GNT  = '0;
    bus.MY_XPOS = 2'd1;
    bus.MY_YPOS = 2'd1;
`ifdef RTR_INPUT_PERF_CNT_EN
    perf_clr    = 1'b0;
`endif
    test_reset();
    test_single_east();
    test_packet_north();
    test_fill_drop();
    test_full_enq_gnt();
    test_local_and_empty_gnt();
    test_proto_err();
    test_reset_midpacket();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_input_unit.md
Name: router_input_unit

Overview:
Parametrised input-port unit for the mesh NoC router.
- Accepts flits from one upstream link into NUM_VC virtual-channel FIFOs.
- Generates per-VC ack, ready and lock handshakes back upstream.
- Computes XY dimension-order routes from head flits and presents each VC head flit, with a one-hot output-port request, to the switch allocator.
- Successor to the fixed 2-VC, 35-bit port logic: width, VC count, depth and coordinate width are all generic.

Parameters:
DATA_W, 35, flit width; [DATA_W-1:DATA_W-2] = type (00 body, 01 head, 10 tail, 11 single); head flit [XW-1:0] = dest X, [XW+YW-1:XW] = dest Y
NUM_VC, 2, virtual channels (>=1)
DEPTH, 4, flits per VC FIFO (power of 2, >=2)
XW, 2, X coordinate width
YW, 2, Y coordinate width
NUM_PORT, 5, router ports; 0 local, 1 north (y-), 2 east (x+), 3 south (y+), 4 west (x-)

Ports:
clk  in  1  clock; all logic on rising edge
RST  in  1  synchronous reset, active-high
IDATA  in  DATA_W  incoming flit
IVALID  in  1  flit valid
IVCH  in  VCW=max(1,$clog2(NUM_VC))  target VC of incoming flit
OACK  out  NUM_VC  one-cycle accept pulse per VC
ORDY  out  NUM_VC  VC has a free slot
OLCK  out  NUM_VC  VC holds an incomplete packet
MY_XPOS  in  XW  router X coordinate
MY_YPOS  in  YW  router Y coordinate
SW_DATA  out  NUM_VC*DATA_W  head-of-FIFO flit per VC
SW_VALID  out  NUM_VC  VC head flit requests the switch
SW_PORT  out  NUM_VC*NUM_PORT  one-hot requested output port per VC
SW_GNT  in  NUM_VC  dequeue the head of the VC this cycle
ERR  out  1  sticky protocol-error flag

Behaviour:
- Reset: FIFOs empty, route registers 0, OACK=0, ORDY=all 1s, OLCK=0, SW_VALID=0, ERR=0. Reset mid-packet discards all contents; there is no partial recovery.
- Enqueue:
  - Occurs when IVALID and ORDY[IVCH], with IVCH < NUM_VC.
  - OACK[IVCH]=1 in the next cycle only.
  - The flit is visible on SW_DATA/SW_VALID the cycle after the write edge: one-cycle latency.
- Drop: IVALID with ORDY[IVCH]=0, or IVCH >= NUM_VC, drops the flit, sends no ack, and sets ERR.
- ORDY: registered; ORDY[v] = (next count[v] < DEPTH). Enqueue and dequeue in the same cycle leave the count unchanged and ORDY stable.
- OLCK[v]:
  - Set the cycle after a type-01 flit is enqueued.
  - Cleared the cycle after a type-10 flit is enqueued.
  - Type 11 does not change it.
  - Head/single arriving while OLCK[v]=1, or body/tail arriving while OLCK[v]=0: set ERR; the flit is still stored.
- Route computation (combinational from FIFO head):
  - Applies when the head type is 01 or 11 (XY routing).
  - dstX > MY_XPOS selects port 2; dstX < MY_XPOS selects port 4.
  - Otherwise dstY > MY_YPOS selects port 3; dstY < MY_YPOS selects port 1.
  - Otherwise port 0.
  - Comparisons are unsigned.
- Route register: body/tail heads use route_q[v], latched when a type-01 flit is dequeued.
- SW_VALID[v] = FIFO v non-empty.
- SW_GNT:
  - SW_GNT[v] dequeues one flit.
  - SW_GNT[v] while SW_VALID[v]=0 is ignored and sets ERR.
  - Multiple VCs may be granted in one cycle.
- FIFO pointers: log2(DEPTH) bits with natural wrap. Count is log2(DEPTH)+1 bits and never exceeds DEPTH.
- ERR: cleared only by RST.

Optional Feature:
RTR_INPUT_PERF_CNT_EN
- Defined: adds output PERF_FLITS (NUM_VC*16) and input PERF_CLR.
  - Per-VC 16-bit counter of enqueued flits, saturating at 0xFFFF.
  - PERF_CLR zeros all counters synchronously; a simultaneous enqueue in that cycle is not counted.
  - Counters reset to 0 on RST.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package router_pkg:
  - Flit-type constants FLIT_BODY/HEAD/TAIL/SINGLE.
  - Port indices PORT_LOCAL/N/E/S/W.
  - NUM_PORT.
  - Field-offset localparams for type and destination bits.
- One sub-module, router_vc_fifo (DATA_W, DEPTH): single-VC circular buffer with count, full/empty and registered ORDY, instantiated NUM_VC times.
- XY route function placed in the package.

Test Plan:
- MY=(1,1); single flit type 11 dest (3,1) on VC0 -> OACK=01 one cycle later; SW_VALID[0]=1 next cycle; SW_PORT[0]=00100 (east).
- 4-flit packet (head dest (1,0), 2 body, tail) on VC1; SW_GNT held -> OLCK[1] high from head+1 until tail+1; all 4 flits report 00010 (north).
- Fill VC0 with DEPTH=4 flits, no grants -> ORDY[0]=0 after 4th; 5th flit dropped, no OACK, ERR=1; VC1 still accepts.
- Full VC0 with simultaneous enqueue-attempt and grant -> flit dropped (ORDY low); next cycle ORDY[0]=1; count=3.
- Dest equals (1,1) -> port 00001 (local); SW_GNT[1] with VC1 empty -> ERR=1, no state change.
- RST asserted mid-packet with 3 flits queued -> next cycle SW_VALID=0, OLCK=0, ORDY=11, ERR=0.
